// File: rtl/tx_sequencer_if.sv
// Memory-read and UART-TX signal bundle between tx_sequencer and its peers.
// master = sequencer side, slave = memory / UART side.
interface tx_sequencer_if #(
    parameter int AW = 10
) ();
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          tx_flag;
    logic          send;
    logic [7:0]    tx_output;

    modport master (
        output rd_en,
        output rd_addr,
        output send,
        output tx_output,
        input  rd_data,
        input  tx_flag
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        input  send,
        input  tx_output,
        output rd_data,
        output tx_flag
    );
endinterface

// File: rtl/tx_sequencer.sv
// UART transmit sequencer: streams a byte-wide result vector, or the
// 16-bit scalar result MSB first, through the UART TX core.
module tx_sequencer #(
    parameter int NBytes = 1024,
    parameter int AW     = $clog2(NBytes)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           mode,
    input  logic [15:0]    scalar_result,
    tx_sequencer_if.master bus,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        SEND,
        WAIT_TX,
        ADVANCE,
        DONE
    } state_e;

    localparam logic [AW-1:0] LastVec = AW'(NBytes - 1);
    localparam logic [AW-1:0] LastScl = AW'(1);

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [15:0]   scalar_q, scalar_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          send_q, send_d;
    logic [7:0]    tx_output_q, tx_output_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] last_idx;
    logic [7:0]    scalar_byte;

    assign last_idx    = mode_q ? LastScl : LastVec;
    assign scalar_byte = idx_q[0] ? scalar_q[7:0] : scalar_q[15:8];

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        scalar_d    = scalar_q;
        idx_d       = idx_q;
        tx_output_d = tx_output_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    scalar_d = scalar_result;
                    idx_d    = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: state_d = WAIT_DATA;
            WAIT_DATA: begin
                tx_output_d = mode_q ? scalar_byte : bus.rd_data;
                state_d     = SEND;
            end
            SEND: state_d = WAIT_TX;
            WAIT_TX: begin
                if (bus.tx_flag) begin
                    if (idx_q == last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ADVANCE;
                    end
                end
            end
            // Spacer so the next read issues two cycles after tx_flag.
            ADVANCE: state_d = FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        rd_en_d   = (state_d == FETCH) && !mode_d;
        rd_addr_d = rd_en_d ? idx_d : rd_addr_q;
        send_d    = (state_d == SEND);
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            scalar_q    <= '0;
            idx_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            send_q      <= 1'b0;
            tx_output_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            scalar_q    <= scalar_d;
            idx_q       <= idx_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            send_q      <= send_d;
            tx_output_q <= tx_output_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.send      = send_q;
    assign bus.tx_output = tx_output_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_tx_sequencer.sv
// Directed-plus-random bench for tx_sequencer with a 4-byte memory,
// a latency-accurate memory model and a randomized-delay UART model.
module tb_tx_sequencer;

    localparam int NB = 4;
    localparam int AWB = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] scalar_result;
    logic        busy;
    logic        done;

    tx_sequencer_if #(.AW(AWB)) bus ();

    tx_sequencer #(.NBytes(NB)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mode          (mode),
        .scalar_result (scalar_result),
        .bus           (bus),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory: data appears one cycle after rd_en, junk otherwise.
    logic [7:0]     mem [NB];
    bit             pend = 1'b0;
    logic [AWB-1:0] pend_addr = '0;
    always @(negedge clk) begin
        bus.rd_data = pend ? mem[pend_addr] : 8'($urandom);
        pend        = (bus.rd_en === 1'b1);
        pend_addr   = bus.rd_addr;
    end

    // UART: tx_flag for one cycle, a delay after each send.
    logic uart_flag = 1'b0;
    logic spur;
    bit   uart_en;
    int   fixed_delay;
    int   cnt = 0;
    int   flag_cyc[$];
    assign bus.tx_flag = uart_flag | spur;
    always @(negedge clk) begin
        uart_flag = 1'b0;
        if (reset !== 1'b0 || !uart_en) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    uart_flag = 1'b1;
                    flag_cyc.push_back(cyc);
                end
            end
            if (bus.send === 1'b1)
                cnt = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 25));
        end
    end

    // Observed traffic.
    logic [7:0]     sent_q[$];
    logic [AWB-1:0] addr_q[$];
    int             rd_cyc[$];
    int             done_cyc[$];
    int             done_cnt = 0;
    int             unstable = 0;
    logic [7:0]     last_tx = 8'h00;
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            last_tx = 8'h00;
        end else begin
            if (bus.send === 1'b1) begin
                sent_q.push_back(bus.tx_output);
                last_tx = bus.tx_output;
            end else if (bus.tx_output !== last_tx) begin
                unstable++;
            end
            if (bus.rd_en === 1'b1) begin
                addr_q.push_back(bus.rd_addr);
                rd_cyc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Returns one cycle after done so done_cnt has been updated.
    task automatic wait_done(input int limit, output bit seen,
                             output int busy_low, output logic busy_at);
        seen = 1'b0;
        busy_low = 0;
        busy_at = 1'bx;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (done === 1'b1) begin
                seen = 1'b1;
                busy_at = busy;
            end else if (busy !== 1'b1) begin
                busy_low++;
            end
        end
        step();
    endtask

    // Reference: bytes are mem[0..NB-1] read at addresses 0..NB-1, or the
    // scalar high byte then low byte with no reads; exactly one done.
    task automatic check_xfer(input string tag, input bit m,
                              input logic [15:0] sc, input int bs,
                              input int ba, input int bd);
        int n;
        logic [7:0] want;
        n = m ? 2 : NB;
        chk({tag, "_nbytes"}, sent_q.size() - bs, n);
        for (int i = 0; i < n; i++) begin
            if (m) want = (i == 0) ? sc[15:8] : sc[7:0];
            else   want = mem[i];
            if (bs + i < sent_q.size())
                chk($sformatf("%s_byte%0d", tag, i), sent_q[bs + i], want);
        end
        chk({tag, "_nreads"}, addr_q.size() - ba, m ? 0 : n);
        if (!m) begin
            for (int i = 0; i < n; i++)
                if (ba + i < addr_q.size())
                    chk($sformatf("%s_addr%0d", tag, i), addr_q[ba + i], i);
        end
        chk({tag, "_ndone"}, done_cnt - bd, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         seen;
        int         blow;
        logic       bat;
        int         bs, ba, bd, bf, br, bdc;
        logic [15:0] sc;
        bit         m2;

        reset = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        scalar_result = 16'h0;
        spur = 1'b0;
        uart_en = 1'b1;
        fixed_delay = 0;
        for (int i = 0; i < NB; i++) mem[i] = 8'h00;
        repeat (3) step();

        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_send", bus.send, 0);
        chk("rst_tx_output", bus.tx_output, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        step();

        // Vector transfer, fixed 20-cycle UART, latency checks.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        fixed_delay = 20;
        bs = sent_q.size(); ba = addr_q.size(); bd = done_cnt;
        bf = flag_cyc.size(); br = rd_cyc.size(); bdc = done_cyc.size();
        start = 1'b1; mode = 1'b0; scalar_result = 16'($urandom);
        step();
        start = 1'b0;
        chk("t1_rd_en_t1", bus.rd_en, 1);
        chk("t1_rd_addr_t1", bus.rd_addr, 0);
        chk("t1_busy_t1", busy, 1);
        chk("t1_send_t1", bus.send, 0);
        step();
        chk("t1_send_t2", bus.send, 0);
        step();
        chk("t1_send_t3", bus.send, 1);
        chk("t1_tx_t3", bus.tx_output, 8'h11);
        wait_done(1000, seen, blow, bat);
        chk("t1_done_seen", seen, 1);
        chk("t1_busy_gaps", blow, 0);
        chk("t1_busy_at_done", bat, 0);
        check_xfer("t1", 1'b0, 16'h0, bs, ba, bd);
        chk("t1_nflags", flag_cyc.size() - bf, NB);
        if (flag_cyc.size() - bf == NB && rd_cyc.size() - br == NB) begin
            for (int i = 0; i < NB - 1; i++)
                chk($sformatf("t1_flag_to_rd%0d", i),
                    rd_cyc[br + i + 1] - flag_cyc[bf + i], 2);
            if (done_cyc.size() > bdc)
                chk("t1_flag_to_done",
                    done_cyc[bdc] - flag_cyc[bf + NB - 1], 1);
        end
        repeat (3) step();
        chk("t1_idle_busy", busy, 0);

        // Scalar transfer; scalar_result changes after start.
        fixed_delay = 0;
        bs = sent_q.size(); ba = addr_q.size(); bd = done_cnt;
        start = 1'b1; mode = 1'b1; scalar_result = 16'hBEEF;
        step();
        start = 1'b0; scalar_result = 16'h0000;
        wait_done(1000, seen, blow, bat);
        chk("t2_done_seen", seen, 1);
        chk("t2_busy_gaps", blow, 0);
        check_xfer("t2", 1'b1, 16'hBEEF, bs, ba, bd);

        // start held every cycle, random mode mid-transfer.
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
        bs = sent_q.size(); ba = addr_q.size(); bd = done_cnt;
        start = 1'b1; mode = 1'b0; scalar_result = 16'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            step();
            mode = 1'($urandom);
            scalar_result = 16'($urandom);
            if (done === 1'b1) seen = 1'b1;
        end
        step();
        start = 1'b0;
        mode = 1'b0;
        chk("t3_done_seen", seen, 1);
        repeat (10) step();
        chk("t3_no_restart", busy, 0);
        check_xfer("t3", 1'b0, 16'h0, bs, ba, bd);

        // Spurious tx_flag in IDLE, FETCH and SEND.
        bs = sent_q.size(); ba = addr_q.size(); bd = done_cnt;
        spur = 1'b1;
        step();
        spur = 1'b0;
        repeat (2) step();
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_sends", sent_q.size() - bs, 0);
        chk("t4_idle_reads", addr_q.size() - ba, 0);
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        chk("t4_send_t3", bus.send, 1);
        spur = 1'b1;
        step();
        spur = 1'b0;
        wait_done(1000, seen, blow, bat);
        chk("t4_done_seen", seen, 1);
        check_xfer("t4", 1'b0, 16'h0, bs, ba, bd);

        // Reset while waiting on byte 2's tx_flag, then restart.
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
        bs = sent_q.size(); bf = flag_cyc.size();
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 200 && flag_cyc.size() == bf; i++) step();
        uart_en = 1'b0;
        for (int i = 0; i < 200 && sent_q.size() - bs < 2; i++) step();
        repeat (40) step();
        chk("t5_nbytes_hung", sent_q.size() - bs, 2);
        chk("t5_busy_hung", busy, 1);
        chk("t5_send_hung", bus.send, 0);
        reset = 1'b1;
        step();
        chk("t5_rst_rd_en", bus.rd_en, 0);
        chk("t5_rst_rd_addr", bus.rd_addr, 0);
        chk("t5_rst_send", bus.send, 0);
        chk("t5_rst_tx_output", bus.tx_output, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        step();
        reset = 1'b0;
        uart_en = 1'b1;
        repeat (20) step();
        chk("t5_no_send_after", sent_q.size() - bs, 2);
        bs = sent_q.size(); ba = addr_q.size(); bd = done_cnt;
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        wait_done(1000, seen, blow, bat);
        chk("t5_done_seen", seen, 1);
        check_xfer("t5", 1'b0, 16'h0, bs, ba, bd);

        // Back-to-back: start in the cycle after done.
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
        bs = sent_q.size(); ba = addr_q.size(); bd = done_cnt;
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        wait_done(1000, seen, blow, bat);
        chk("t6a_done_seen", seen, 1);
        check_xfer("t6a", 1'b0, 16'h0, bs, ba, bd);
        m2 = 1'($urandom);
        sc = 16'($urandom);
        bs = sent_q.size(); ba = addr_q.size(); bd = done_cnt;
        start = 1'b1; mode = m2; scalar_result = sc;
        step();
        start = 1'b0;
        chk("t6_busy_t1", busy, 1);
        chk("t6_rd_en_t1", bus.rd_en, !m2);
        wait_done(1000, seen, blow, bat);
        chk("t6b_done_seen", seen, 1);
        chk("t6b_busy_gaps", blow, 0);
        check_xfer("t6b", m2, sc, bs, ba, bd);

        chk("tx_hold_stable", unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
